// File: rtl/gpio_pixel_uart_sink.sv
// GPIO pixel sink: assembles {R,G,B} from GPIO strobes, queues pixels
// and streams each one as three 8N1 UART bytes (R, G, B).
module gpio_pixel_uart_sink #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] GPIO,
  input  logic        GPIOEnR,
  input  logic        GPIOEnG,
  input  logic        GPIOEnB,
  input  logic        ovf_clr,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow,
  output logic [31:0] pixel_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0] LVL_ONE = 1;
  localparam logic [AW:0] LVL_MAX = FIFO_DEPTH;
  localparam logic [CW-1:0] TICK_ONE = 1;
  localparam logic [CW-1:0] TICK_LAST = CLKS_PER_BIT - 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    r, g, b;
  logic          vr, vg, vb;
  logic          push, pop, accept, drop;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   level;
  state_t        state;
  logic [CW-1:0] tick;
  logic          last;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   shreg;
  logic          unused_gpio;

  assign unused_gpio = ^GPIO[31:8];

  assign push      = vr & vg & vb;
  assign pop       = (state == IDLE) && (level != '0);
  assign fifo_full = (level == LVL_MAX);
  assign accept    = push & (~fifo_full | pop);
  assign drop      = push & ~accept;
  assign busy      = (state != IDLE) || (level != '0);
  assign last      = (tick == TICK_LAST);

  // Strobes after the flag clear so a same-cycle strobe starts the next pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r  <= '0;
      g  <= '0;
      b  <= '0;
      vr <= 1'b0;
      vg <= 1'b0;
      vb <= 1'b0;
    end else begin
      if (push) begin
        vr <= 1'b0;
        vg <= 1'b0;
        vb <= 1'b0;
      end
      if (GPIOEnR) begin
        r  <= GPIO[7:0];
        vr <= 1'b1;
      end
      if (GPIOEnG) begin
        g  <= GPIO[7:0];
        vg <= 1'b1;
      end
      if (GPIOEnB) begin
        b  <= GPIO[7:0];
        vb <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wp] <= {r, g, b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      pixel_count <= '0;
    end else begin
      if (accept) begin
        wp          <= wp + 1'b1;
        pixel_count <= pixel_count + 32'd1;
      end
      if (pop) rp <= rp + 1'b1;
      if (accept && !pop) level <= level + LVL_ONE;
      else if (!accept && pop) level <= level - LVL_ONE;
      if (drop) overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // The current byte always sits in shreg[23:16]; it shifts right per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tick     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tx   <= 1'b1;
          tick <= '0;
          if (pop) begin
            shreg    <= mem[rp];
            byte_idx <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (last) begin
            tick          <= '0;
            bit_idx       <= '0;
            tx            <= shreg[16];
            shreg[23:16]  <= {1'b0, shreg[23:17]};
            state         <= DATA;
          end else begin
            tick <= tick + TICK_ONE;
          end
        end
        DATA: begin
          if (last) begin
            tick <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx      <= bit_idx + 3'd1;
              tx           <= shreg[16];
              shreg[23:16] <= {1'b0, shreg[23:17]};
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end
        STOP: begin
          if (last) begin
            tick <= '0;
            if (byte_idx == 2'd2) begin
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              shreg    <= {shreg[15:0], 8'h00};
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
